dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, staging buffer entries (power of two).
REQ-004 SHALL have ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low.
- cfg_start  input  1  one-cycle start pulse.
- cfg_dst_addr  input  ADDR_W  first destination memory address.
- cfg_len  input  ADDR_W  word count.
- io_valid  input  1  I/O source word available.
- io_data  input  DATA_W  I/O source word.
- io_ready  output  1  engine accepts io_data this cycle.
- bus_req  output  1  memory bus request to the CPU.
- bus_grant  input  1  CPU yields the memory bus.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement states IDLE, ACTIVE, DONE.
REQ-006 IDLE: cfg_start with cfg_len!=0 SHALL latch cfg_dst_addr into cur_addr, load rx_cnt and wr_cnt with cfg_len, and enter ACTIVE next cycle.
REQ-007 IDLE: cfg_start with cfg_len==0 SHALL pulse done next cycle, remain in IDLE, and write nothing.
REQ-008 cfg_start while busy SHALL be ignored, with no change to the latched configuration.
REQ-009 ACTIVE: io_ready SHALL equal (rx_cnt!=0) && !fifo_full; io_valid&&io_ready SHALL push io_data and decrement rx_cnt.
REQ-010 A push SHALL NOT occur when the FIFO is full, even if a pop happens in the same cycle.
REQ-011 ACTIVE: bus_req SHALL equal fifo_not_empty, registered-free (combinational from state).
REQ-012 mem_we SHALL equal bus_req && bus_grant; mem_wdata SHALL be the FIFO head and mem_addr SHALL be cur_addr in that same cycle, for a write latency of zero cycles from grant.
REQ-013 Each mem_we SHALL pop one word, increment cur_addr modulo 2^ADDR_W (0xFF wraps to 0x00), and decrement wr_cnt.
REQ-014 When wr_cnt goes 1->0, the engine SHALL enter DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-015 bus_grant without bus_req SHALL have no effect.
REQ-016 busy SHALL be 1 in ACTIVE and DONE and 0 in IDLE.
REQ-017 Outside a write, mem_we and mem_wdata SHALL be 0; mem_addr SHALL hold cur_addr.
REQ-018 Words SHALL be written in the exact arrival order with no loss or duplication under any io_valid/bus_grant pattern.

Reset
REQ-019 reset low SHALL asynchronously force IDLE, empty the FIFO, zero all counters and cur_addr, and drive io_ready, bus_req, mem_we, mem_addr, mem_wdata, busy and done to 0.
REQ-020 Reset mid-transfer SHALL abort the transfer with no done pulse; buffered words SHALL be discarded.

Configuration
REQ-021 With macro DMA_ENGINE_IRQ_EN defined: output irq and input irq_clr SHALL exist; irq SHALL set on the done pulse, hold until irq_clr is 1, and reset to 0; if irq_clr and done coincide, set SHALL win.
REQ-022 Without DMA_ENGINE_IRQ_EN: irq and irq_clr SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-023 A shared package dma_pkg SHALL hold the state enum (IDLE/ACTIVE/DONE) and the default width/depth constants.
REQ-024 The FIFO SHALL be a sub-module dma_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-025 Test: reset, cfg_start dst=0x10 len=3, io words 0xA,0xB,0xC back-to-back, bus_grant=1 -> MEM[0x10..0x12]=0xA,0xB,0xC; done pulses once; busy returns to 0.
REQ-026 Test: len=6, bus_grant=0 for 10 cycles -> io_ready drops after 4 accepts, bus_req stays 1, and there is no mem_we; granting then completes all 6 writes in order.
REQ-027 Test: dst=0xFE, len=3 -> writes land at 0xFE, 0xFF, 0x00.
REQ-028 Test: cfg_len=0 -> done pulses one cycle later, busy stays 0, and there is no mem_we.
REQ-029 Test: reset asserted after 2 of 5 words are written -> all outputs go to 0 immediately, there is no done pulse, and a new len=1 transfer completes normally.
REQ-030 Test: second cfg_start mid-transfer with different dst/len -> ignored; the original transfer completes unchanged. With DMA_ENGINE_IRQ_EN, irq holds high until irq_clr.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and default sizing for the DMA engine
//
// Holds the engine state enum and the default data width, address width and
// staging-buffer depth used as parameter defaults by dma_engine and dma_fifo.

package dma_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } dma_state_t;

endpackage

// File: rtl/dma_fifo.sv
// rtl/dma_fifo.sv - synchronous staging FIFO between the I/O side and the memory bus
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset; empties the FIFO
//   push      write push_data into the tail (ignored when full)
//   push_data word to write
//   pop       drop the head word (ignored when empty)
//   full      no free entry
//   empty     no stored entry
//   head      oldest stored word (stale when empty)

module dma_fifo import dma_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - single-channel I/O-to-memory DMA engine with bus request/grant
//
// Optional feature macro: DMA_ENGINE_IRQ_EN adds a sticky completion interrupt.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset; aborts any transfer
//   cfg_start     one-cycle start pulse (ignored while busy)
//   cfg_dst_addr  first destination address
//   cfg_len       number of words to move (0 gives an immediate done pulse)
//   io_valid      source word available
//   io_data       source word
//   io_ready      engine accepts io_data this cycle
//   bus_req       request for the memory bus (buffered data waiting)
//   bus_grant     CPU yields the bus
//   mem_we        memory write strobe (bus_req && bus_grant)
//   mem_addr      current destination address
//   mem_wdata     write data, zero outside a write
//   busy          transfer in progress
//   done          one-cycle completion pulse
//   irq           (DMA_ENGINE_IRQ_EN) set on done, held until irq_clr
//   irq_clr       (DMA_ENGINE_IRQ_EN) clears irq; a coincident done wins

module dma_engine import dma_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic              io_valid,
    input  logic [DATA_W-1:0] io_data,
    output logic              io_ready,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
`ifdef DMA_ENGINE_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] rx_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic              zero_done;
    logic              start_ok;
    logic              start_zero;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign start_ok   = (state == IDLE) && cfg_start && (cfg_len != '0);
    assign start_zero = (state == IDLE) && cfg_start && (cfg_len == '0);

    always_comb begin
        state_nxt = state;
        io_ready  = 1'b0;
        bus_req   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                busy     = 1'b1;
                io_ready = (rx_cnt != '0) && !fifo_full;
                bus_req  = !fifo_empty;
                if (bus_req && bus_grant && (wr_cnt == ADDR_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Writes happen in the grant cycle itself; a grant with no request is inert
    // because bus_req gates the strobe.
    assign push      = io_valid && io_ready;
    assign mem_we    = bus_req && bus_grant;
    assign pop       = mem_we;
    assign mem_addr  = cur_addr;
    assign mem_wdata = mem_we ? fifo_head : '0;
    // A zero-length start never leaves IDLE, so its pulse comes from a flag.
    assign done      = (state == DONE) || zero_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            rx_cnt    <= '0;
            wr_cnt    <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_done <= start_zero;
            if (start_ok) begin
                cur_addr <= cfg_dst_addr;
                rx_cnt   <= cfg_len;
                wr_cnt   <= cfg_len;
            end else begin
                if (push) begin
                    rx_cnt <= rx_cnt - ADDR_W'(1);
                end
                if (pop) begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    wr_cnt   <= wr_cnt - ADDR_W'(1);
                end
            end
        end
    end

    dma_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (io_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

`ifdef DMA_ENGINE_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - randomized self-checking bench for dma_engine against a queue model

module tb_dma_engine;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [AW-1:0] cfg_dst_addr;
    logic [AW-1:0] cfg_len;
    logic          io_valid;
    logic [DW-1:0] io_data;
    logic          io_ready;
    logic          bus_req;
    logic          bus_grant;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
`ifdef DMA_ENGINE_IRQ_EN
    logic          irq;
    logic          irq_clr;
    bit            m_irq;
    int            clr_pct;
`endif

    dma_engine #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_dst_addr (cfg_dst_addr),
        .cfg_len      (cfg_len),
        .io_valid     (io_valid),
        .io_data      (io_data),
        .io_ready     (io_ready),
        .bus_req      (bus_req),
        .bus_grant    (bus_grant),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done)
`ifdef DMA_ENGINE_IRQ_EN
        ,
        .irq          (irq),
        .irq_clr      (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 moving words, 2 completion cycle.
    int            m_phase;
    bit            m_zero;
    logic [AW-1:0] m_addr;
    int            m_rx;
    int            m_wr;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] src[$];

    int            done_count;
    int            we_count;
    int            acc_count;
    logic          obs_bus_req;
    logic [DW-1:0] dut_mem [256];
    bit            written [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_zero  = 1'b0;
        m_addr  = '0;
        m_rx    = 0;
        m_wr    = 0;
        m_q.delete();
        src.delete();
`ifdef DMA_ENGINE_IRQ_EN
        m_irq = 1'b0;
`endif
    endtask

    // Called at posedge+1; drives inputs, compares at posedge+2, advances the model.
    task automatic step(input bit st, input logic [AW-1:0] dst, input logic [AW-1:0] len,
                        input int pv, input int pg);
        bit            e_ready;
        bit            e_req;
        bit            e_we;
        bit            e_done;
        logic [DW-1:0] e_wdata;
        cfg_start    = st;
        cfg_dst_addr = dst;
        cfg_len      = len;
        io_valid     = (src.size() > 0) && (int'($urandom_range(99)) < pv);
        io_data      = (src.size() > 0) ? src[0] : DW'($urandom);
        bus_grant    = int'($urandom_range(99)) < pg;
`ifdef DMA_ENGINE_IRQ_EN
        irq_clr      = int'($urandom_range(99)) < clr_pct;
`endif
        #1;
        e_ready = (m_phase == 1) && (m_rx != 0) && (m_q.size() < DEPTH);
        e_req   = (m_phase == 1) && (m_q.size() > 0);
        e_we    = e_req && bus_grant;
        e_wdata = e_we ? m_q[0] : '0;
        e_done  = (m_phase == 2) || m_zero;
        chk("io_ready", io_ready, e_ready);
        chk("bus_req", bus_req, e_req);
        chk("mem_we", mem_we, e_we);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_addr", mem_addr, m_addr);
        chk("busy", busy, m_phase != 0);
        chk("done", done, e_done);
`ifdef DMA_ENGINE_IRQ_EN
        chk("irq", irq, m_irq);
        if (e_done) m_irq = 1'b1;
        else if (irq_clr) m_irq = 1'b0;
`endif
        if (done === 1'b1) done_count++;
        if (mem_we === 1'b1) begin
            we_count++;
            dut_mem[mem_addr] = mem_wdata;
            written[mem_addr] = 1'b1;
        end
        if (io_valid && io_ready === 1'b1) acc_count++;
        obs_bus_req = bus_req;
        m_zero = 1'b0;
        case (m_phase)
            0: begin
                if (st) begin
                    if (len != 0) begin
                        m_phase = 1;
                        m_addr  = dst;
                        m_rx    = int'(len);
                        m_wr    = int'(len);
                    end else begin
                        m_zero = 1'b1;
                    end
                end
            end
            1: begin
                if (e_we) begin
                    void'(m_q.pop_front());
                    m_addr = m_addr + 8'd1;
                    m_wr--;
                    if (m_wr == 0) m_phase = 2;
                end
                if (io_valid && e_ready) begin
                    m_q.push_back(src.pop_front());
                    m_rx--;
                end
            end
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int pv, input int pg, input bit stray, input string name);
        int n;
        bit st;
        n = 0;
        while ((m_phase != 0 || m_zero) && n < 400) begin
            st = stray && (m_phase == 1) && ($urandom_range(99) < 5);
            step(st, AW'($urandom), AW'($urandom_range(1, 15)), pv, pg);
            n++;
        end
        checks++;
        if (m_phase != 0 || m_zero) begin
            failures++;
            $display("FAIL timeout_%s actual=busy expected=idle within 400 cycles", name);
        end
    endtask

    task automatic load_src(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) src.push_back(base + DW'(i));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        int a0;
        int n;
        int len;
        model_reset();
        done_count = 0;
        we_count   = 0;
        acc_count  = 0;
`ifdef DMA_ENGINE_IRQ_EN
        clr_pct = 0;
        irq_clr = 1'b0;
`endif
        reset = 1'b0;
        cfg_start = 1'b0; cfg_dst_addr = '0; cfg_len = '0;
        io_valid = 1'b0; io_data = '0; bus_grant = 1'b0;
        #2;
        chk("rst_io_ready", io_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Three words back to back with the bus always granted.
        src.push_back(32'hA); src.push_back(32'hB); src.push_back(32'hC);
        step(1'b1, 8'h10, 8'd3, 100, 100);
        run_idle(100, 100, 1'b0, "basic");
        chk("basic_mem10", dut_mem[8'h10], 32'hA);
        chk("basic_mem11", dut_mem[8'h11], 32'hB);
        chk("basic_mem12", dut_mem[8'h12], 32'hC);
        chk("basic_done_count", done_count, 1);
        chk("basic_busy_end", busy, 0);

        // Bus withheld: buffer fills after four accepts, request held, no writes.
        load_src(32'h100, 6);
        step(1'b1, 8'h40, 8'd6, 100, 0);
        a0 = acc_count;
        w0 = we_count;
        repeat (10) step(1'b0, 8'h00, 8'h00, 100, 0);
        chk("stall_accepts", acc_count - a0, 4);
        chk("stall_writes", we_count - w0, 0);
        chk("stall_bus_req", obs_bus_req, 1);
        run_idle(100, 100, 1'b0, "stall");
        for (int i = 0; i < 6; i++) chk("stall_mem", dut_mem[8'h40 + i], 32'h100 + i);

        // Address wrap.
        load_src(32'h21, 3);
        step(1'b1, 8'hFE, 8'd3, 100, 100);
        run_idle(60, 50, 1'b0, "wrap");
        chk("wrap_memFE", dut_mem[8'hFE], 32'h21);
        chk("wrap_memFF", dut_mem[8'hFF], 32'h22);
        chk("wrap_mem00", dut_mem[8'h00], 32'h23);

        // Zero length: one done pulse next cycle, no write, never busy.
        d0 = done_count;
        w0 = we_count;
        step(1'b1, 8'h50, 8'd0, 0, 100);
        step(1'b0, 8'h00, 8'h00, 0, 100);
        step(1'b0, 8'h00, 8'h00, 0, 100);
        chk("zero_done_count", done_count - d0, 1);
        chk("zero_writes", we_count - w0, 0);
        chk("zero_busy", busy, 0);

        // Reset after two of five writes.
        load_src(32'h501, 5);
        step(1'b1, 8'h80, 8'd5, 100, 100);
        w0 = we_count;
        n = 0;
        while (we_count - w0 < 2 && n < 20) begin
            step(1'b0, 8'h00, 8'h00, 100, 100);
            n++;
        end
        chk("abort_two_written", we_count - w0, 2);
        reset = 1'b0;
        #1;
        chk("abort_io_ready", io_ready, 0);
        chk("abort_bus_req", bus_req, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        model_reset();
        d0 = done_count;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) step(1'b0, 8'h00, 8'h00, 100, 100);
        chk("abort_no_done", done_count - d0, 0);
        chk("abort_mem80", dut_mem[8'h80], 32'h501);
        chk("abort_mem81", dut_mem[8'h81], 32'h502);
        chk("abort_mem82_untouched", written[8'h82], 0);
        src.push_back(32'h77);
        step(1'b1, 8'h05, 8'd1, 100, 100);
        run_idle(100, 100, 1'b0, "after_abort");
        chk("after_abort_mem05", dut_mem[8'h05], 32'h77);
        chk("after_abort_done", done_count - d0, 1);

        // Second start mid-transfer is ignored.
        load_src(32'h301, 4);
        step(1'b1, 8'h30, 8'd4, 100, 100);
        step(1'b1, 8'h99, 8'd7, 50, 50);
        step(1'b1, 8'h99, 8'd7, 50, 50);
        run_idle(70, 60, 1'b0, "restart");
        for (int i = 0; i < 4; i++) chk("restart_mem", dut_mem[8'h30 + i], 32'h301 + i);
        chk("restart_no_99", written[8'h99], 0);
`ifdef DMA_ENGINE_IRQ_EN
        repeat (3) step(1'b0, 8'h00, 8'h00, 0, 0);
        chk("irq_hold", irq, 1);
        clr_pct = 100;
        step(1'b0, 8'h00, 8'h00, 0, 0);
        clr_pct = 0;
        chk("irq_cleared", irq, 0);
`endif

        // Randomized transfers with stray starts and irregular handshakes.
        for (int t = 0; t < 12; t++) begin
            len = int'($urandom_range(0, 9));
            for (int i = 0; i < len; i++) src.push_back(DW'($urandom));
`ifdef DMA_ENGINE_IRQ_EN
            clr_pct = 20;
`endif
            step(1'b1, AW'($urandom), AW'(len), 100, 100);
            run_idle(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 1'b1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
